// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, round-robin grant, ROB-relative flush.
// Optional CDB_ARBITER_MISPREDICT_PRIORITY_EN lets mispredicting results jump the round-robin order.
module cdb_arbiter #(
   parameter int XLEN          = 32,
   parameter int N_PORTS       = 4,
   parameter int ROB_BUF_SIZE  = 16,
   parameter int ROB_TAG_WIDTH = $clog2(ROB_BUF_SIZE) + 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [N_PORTS-1:0]               fu_valid,
   output logic [N_PORTS-1:0]               fu_ready,
   input  logic [N_PORTS*XLEN-1:0]          fu_data,
   input  logic [N_PORTS*ROB_TAG_WIDTH-1:0] fu_rob_tag,
   input  logic [N_PORTS-1:0]               fu_exception,
   input  logic [N_PORTS-1:0]               fu_branch_mispredict,
   input  logic                             flush,
   input  logic [ROB_TAG_WIDTH-1:0]         flush_start_tag,
   input  logic [ROB_TAG_WIDTH-1:0]         rob_head,
   output logic                             cdb_valid,
   output logic [XLEN-1:0]                  cdb_data,
   output logic [ROB_TAG_WIDTH-1:0]         cdb_rob_tag,
   output logic                             cdb_exception,
   output logic                             branch_mispredict
);

   localparam int IW = (ROB_BUF_SIZE > 1) ? $clog2(ROB_BUF_SIZE) : 1;
   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int TW = ROB_TAG_WIDTH;

   logic [N_PORTS-1:0]  slot_valid;
   logic [XLEN-1:0]     slot_data [N_PORTS];
   logic [TW-1:0]       slot_tag  [N_PORTS];
   logic [N_PORTS-1:0]  slot_exc;
   logic [N_PORTS-1:0]  slot_mis;

   logic [PW-1:0]       last_grant;
   logic [N_PORTS-1:0]  slot_kill;
   logic [N_PORTS-1:0]  in_kill;
   logic [N_PORTS-1:0]  eligible;
   logic [N_PORTS-1:0]  grant;
   logic [N_PORTS-1:0]  take;
   logic                grant_any;
   logic [PW-1:0]       grant_idx;
   logic [PW-1:0]       cand_idx;
   logic [IW-1:0]       flush_age;

   // Only the ROB index bits take part in age arithmetic; the wrap bits are ignored.
   logic unused_tag_bits;
   assign unused_tag_bits = ^{rob_head[TW-1:IW], flush_start_tag[TW-1:IW]};

   assign flush_age = flush_start_tag[IW-1:0] - rob_head[IW-1:0];

   for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      logic [IW-1:0] slot_age;
      logic [IW-1:0] in_age;
      assign slot_age      = slot_tag[gi][IW-1:0] - rob_head[IW-1:0];
      assign in_age        = fu_rob_tag[gi*TW +: IW] - rob_head[IW-1:0];
      assign slot_kill[gi] = flush && (slot_age >= flush_age);
      assign in_kill[gi]   = flush && (in_age >= flush_age);
      assign eligible[gi]  = slot_valid[gi] && !slot_kill[gi];
      assign grant[gi]     = grant_any && (grant_idx == PW'(gi));
      assign fu_ready[gi]  = !slot_valid[gi] || grant[gi];
      assign take[gi]      = fu_valid[gi] && fu_ready[gi] && !in_kill[gi];
   end

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand_idx  = '0;
      for (int k = 1; k <= N_PORTS; k++) begin
         cand_idx = PW'((int'(last_grant) + k) % N_PORTS);
         if (!grant_any && eligible[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
`ifdef CDB_ARBITER_MISPREDICT_PRIORITY_EN
      // Descending scan so the lowest-index mispredicting slot wins.
      for (int i = N_PORTS - 1; i >= 0; i--) begin
         if (eligible[PW'(i)] && slot_mis[PW'(i)]) begin
            grant_any = 1'b1;
            grant_idx = PW'(i);
         end
      end
`else
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_valid <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (take[i])
               slot_valid[i] <= 1'b1;
            else if (grant[i] || slot_kill[i])
               slot_valid[i] <= 1'b0;
         end
      end
   end

   // Payload is qualified by slot_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PORTS; i++) begin
         if (take[i]) begin
            slot_data[i] <= fu_data[i*XLEN +: XLEN];
            slot_tag[i]  <= fu_rob_tag[i*TW +: TW];
            slot_exc[i]  <= fu_exception[i];
            slot_mis[i]  <= fu_branch_mispredict[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant        <= PW'(N_PORTS - 1);
         cdb_valid         <= 1'b0;
         cdb_data          <= '0;
         cdb_rob_tag       <= '0;
         cdb_exception     <= 1'b0;
         branch_mispredict <= 1'b0;
      end else if (grant_any) begin
         last_grant        <= grant_idx;
         cdb_valid         <= 1'b1;
         cdb_data          <= slot_data[grant_idx];
         cdb_rob_tag       <= slot_tag[grant_idx];
         cdb_exception     <= slot_exc[grant_idx];
         branch_mispredict <= slot_mis[grant_idx];
      end else begin
         cdb_valid         <= 1'b0;
         cdb_data          <= '0;
         cdb_rob_tag       <= '0;
         cdb_exception     <= 1'b0;
         branch_mispredict <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single port, contention, back-pressure, flush, priority, mid-stream reset.
module tb_cdb_arbiter;

   localparam int XLEN = 32;
   localparam int NP   = 4;
   localparam int TW   = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NP-1:0]     fu_valid;
   logic [NP-1:0]     fu_ready;
   logic [NP*XLEN-1:0] fu_data;
   logic [NP*TW-1:0]  fu_rob_tag;
   logic [NP-1:0]     fu_exception;
   logic [NP-1:0]     fu_branch_mispredict;
   logic              flush;
   logic [TW-1:0]     flush_start_tag;
   logic [TW-1:0]     rob_head;
   logic              cdb_valid;
   logic [XLEN-1:0]   cdb_data;
   logic [TW-1:0]     cdb_rob_tag;
   logic              cdb_exception;
   logic              branch_mispredict;

   int tests = 0;
   int fails = 0;

   cdb_arbiter #(.XLEN(XLEN), .N_PORTS(NP), .ROB_BUF_SIZE(16), .ROB_TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_data(fu_data), .fu_rob_tag(fu_rob_tag),
      .fu_exception(fu_exception), .fu_branch_mispredict(fu_branch_mispredict),
      .flush(flush), .flush_start_tag(flush_start_tag), .rob_head(rob_head),
      .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rob_tag(cdb_rob_tag),
      .cdb_exception(cdb_exception), .branch_mispredict(branch_mispredict)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (cdb_valid)
         $display("[TB] t=%0t cdb tag=%0d data=%h exc=%0b mis=%0b",
                  $time, cdb_rob_tag, cdb_data, cdb_exception, branch_mispredict);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fu_valid = '0;
      fu_data = '0;
      fu_rob_tag = '0;
      fu_exception = '0;
      fu_branch_mispredict = '0;
      flush = 1'b0;
      flush_start_tag = '0;
      rob_head = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic offer(input int p, input logic [XLEN-1:0] d, input logic [TW-1:0] t,
                        input logic exc, input logic mis);
      fu_valid[p] = 1'b1;
      fu_data[p*XLEN +: XLEN] = d;
      fu_rob_tag[p*TW +: TW] = t;
      fu_exception[p] = exc;
      fu_branch_mispredict[p] = mis;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      tests++;
      if (cdb_valid !== 1'b0 || cdb_data !== '0 || cdb_rob_tag !== '0) begin
         fails++;
         $display("FAIL reset_cdb: valid=%b data=%h tag=%0d, want 0/0/0", cdb_valid, cdb_data, cdb_rob_tag);
      end
      tests++;
      if (fu_ready !== 4'hF) begin
         fails++;
         $display("FAIL reset_ready: got %b want 1111", fu_ready);
      end
      reset = 1'b0;
      step();
      tests++;
      if (fu_ready !== 4'hF || cdb_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: ready=%b valid=%b want 1111/0", fu_ready, cdb_valid);
      end
   endtask

   task automatic test_single();
      do_reset();
      offer(0, 32'h7867_5645, 6'd0, 1'b0, 1'b0);
      step();
      fu_valid = '0;
      tests++;
      if (cdb_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_latency: cdb_valid=%b after accept edge, want 0", cdb_valid);
      end
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_data !== 32'h7867_5645 || cdb_rob_tag !== 6'd0) begin
         fails++;
         $display("FAIL single_bcast: valid=%b data=%h tag=%0d want 1/78675645/0", cdb_valid, cdb_data, cdb_rob_tag);
      end
      step();
      tests++;
      if (cdb_valid !== 1'b0 || cdb_data !== '0) begin
         fails++;
         $display("FAIL single_clear: valid=%b data=%h want 0/0", cdb_valid, cdb_data);
      end
   endtask

   task automatic test_contention();
      logic [TW-1:0]   exp_tag;
      logic [XLEN-1:0] exp_data;
      do_reset();
      for (int p = 0; p < NP; p++) offer(p, 32'h100 + 32'(p), 6'(4 + p), 1'b0, 1'b0);
      step();
      fu_valid = '0;
      tests++;
      if (fu_ready !== 4'b0001) begin
         fails++;
         $display("FAIL contention_ready: got %b want 0001", fu_ready);
      end
      for (int i = 0; i < NP; i++) begin
         step();
         exp_tag = 6'(4 + i);
         exp_data = 32'h100 + 32'(i);
         tests++;
         if (cdb_valid !== 1'b1 || cdb_rob_tag !== exp_tag || cdb_data !== exp_data) begin
            fails++;
            $display("FAIL contention_order[%0d]: valid=%b tag=%0d data=%h want 1/%0d/%h",
                     i, cdb_valid, cdb_rob_tag, cdb_data, exp_tag, exp_data);
         end
      end
      step();
      tests++;
      if (cdb_valid !== 1'b0) begin
         fails++;
         $display("FAIL contention_drain: cdb_valid=%b want 0", cdb_valid);
      end
      // last_grant is now 3: port 0 alone, then ports 0 and 1 together must rotate to port 1 first
      offer(0, 32'h800, 6'd8, 1'b0, 1'b0);
      step();
      fu_valid = '0;
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd8) begin
         fails++;
         $display("FAIL rotate_p0: valid=%b tag=%0d want 1/8", cdb_valid, cdb_rob_tag);
      end
      step();
      offer(0, 32'h900, 6'd9, 1'b0, 1'b0);
      offer(1, 32'hA00, 6'd10, 1'b0, 1'b0);
      step();
      fu_valid = '0;
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd10) begin
         fails++;
         $display("FAIL rotate_first: valid=%b tag=%0d want 1/10", cdb_valid, cdb_rob_tag);
      end
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd9) begin
         fails++;
         $display("FAIL rotate_second: valid=%b tag=%0d want 1/9", cdb_valid, cdb_rob_tag);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      offer(0, 32'hA1, 6'd1, 1'b0, 1'b0);
      offer(1, 32'hA2, 6'd2, 1'b0, 1'b0);
      offer(2, 32'hA3, 6'd3, 1'b0, 1'b0);
      step();
      offer(0, 32'hB1, 6'd11, 1'b0, 1'b0);
      offer(1, 32'hB2, 6'd12, 1'b0, 1'b0);
      fu_valid[2] = 1'b0;
      tests++;
      if (fu_ready !== 4'b1001) begin
         fails++;
         $display("FAIL bp_ready_e1: got %b want 1001", fu_ready);
      end
      step();
      offer(0, 32'hC1, 6'd21, 1'b0, 1'b0);
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd1 || fu_ready !== 4'b1010) begin
         fails++;
         $display("FAIL bp_e2: valid=%b tag=%0d ready=%b want 1/1/1010", cdb_valid, cdb_rob_tag, fu_ready);
      end
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd2 || fu_ready !== 4'b1100) begin
         fails++;
         $display("FAIL bp_e3: valid=%b tag=%0d ready=%b want 1/2/1100", cdb_valid, cdb_rob_tag, fu_ready);
      end
      step();
      fu_valid = '0;
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd3 || cdb_data !== 32'hA3) begin
         fails++;
         $display("FAIL bp_port2: valid=%b tag=%0d data=%h want 1/3/a3", cdb_valid, cdb_rob_tag, cdb_data);
      end
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd11 || cdb_data !== 32'hB1) begin
         fails++;
         $display("FAIL bp_refill0: valid=%b tag=%0d data=%h want 1/11/b1", cdb_valid, cdb_rob_tag, cdb_data);
      end
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd12 || cdb_data !== 32'hB2) begin
         fails++;
         $display("FAIL bp_refill1: valid=%b tag=%0d data=%h want 1/12/b2", cdb_valid, cdb_rob_tag, cdb_data);
      end
   endtask

   task automatic test_flush();
      do_reset();
      rob_head = 6'd4;
      offer(0, 32'hF7, 6'd7, 1'b0, 1'b0);
      offer(1, 32'hF8, 6'd8, 1'b0, 1'b0);
      offer(2, 32'hF5, 6'd5, 1'b0, 1'b0);
      offer(3, 32'hF9, 6'd9, 1'b0, 1'b0);
      step();
      fu_valid = '0;
      offer(2, 32'hFA, 6'd10, 1'b0, 1'b0);
      flush = 1'b1;
      flush_start_tag = 6'd7;
      #1;
      tests++;
      if (fu_ready !== 4'b0100) begin
         fails++;
         $display("FAIL flush_ready: got %b want 0100", fu_ready);
      end
      step();
      flush = 1'b0;
      fu_valid = '0;
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd5 || cdb_data !== 32'hF5) begin
         fails++;
         $display("FAIL flush_survivor: valid=%b tag=%0d data=%h want 1/5/f5", cdb_valid, cdb_rob_tag, cdb_data);
      end
      tests++;
      if (fu_ready !== 4'hF) begin
         fails++;
         $display("FAIL flush_cleared: ready=%b want 1111", fu_ready);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (cdb_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_bcast[%0d]: valid=%b tag=%0d want 0", i, cdb_valid, cdb_rob_tag);
         end
      end
   endtask

   task automatic test_priority();
      logic [TW-1:0] first_tag;
      logic [TW-1:0] second_tag;
      logic          first_mis;
      logic          first_exc;
`ifdef CDB_ARBITER_MISPREDICT_PRIORITY_EN
      first_tag = 6'd6; second_tag = 6'd3; first_mis = 1'b1; first_exc = 1'b0;
`else
      first_tag = 6'd3; second_tag = 6'd6; first_mis = 1'b0; first_exc = 1'b1;
`endif
      do_reset();
      offer(0, 32'h33, 6'd3, 1'b1, 1'b0);
      offer(3, 32'h66, 6'd6, 1'b0, 1'b1);
      step();
      fu_valid = '0;
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== first_tag || branch_mispredict !== first_mis
          || cdb_exception !== first_exc) begin
         fails++;
         $display("FAIL prio_first: tag=%0d mis=%b exc=%b want %0d/%b/%b",
                  cdb_rob_tag, branch_mispredict, cdb_exception, first_tag, first_mis, first_exc);
      end
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== second_tag || branch_mispredict !== !first_mis) begin
         fails++;
         $display("FAIL prio_second: tag=%0d mis=%b want %0d/%b", cdb_rob_tag, branch_mispredict, second_tag, !first_mis);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      offer(0, 32'hD1, 6'd1, 1'b0, 1'b0);
      offer(1, 32'hD2, 6'd2, 1'b0, 1'b0);
      offer(2, 32'hD3, 6'd3, 1'b0, 1'b0);
      step();
      fu_valid = '0;
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd1) begin
         fails++;
         $display("FAIL midreset_pre: valid=%b tag=%0d want 1/1", cdb_valid, cdb_rob_tag);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || fu_ready !== 4'hF) begin
         fails++;
         $display("FAIL midreset_async: valid=%b tag=%0d ready=%b want 0/0/1111", cdb_valid, cdb_rob_tag, fu_ready);
      end
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (cdb_valid !== 1'b0 || fu_ready !== 4'hF) begin
            fails++;
            $display("FAIL midreset_quiet[%0d]: valid=%b tag=%0d ready=%b want 0/-/1111", i, cdb_valid, cdb_rob_tag, fu_ready);
         end
      end
      offer(1, 32'hE9, 6'd9, 1'b0, 1'b0);
      step();
      fu_valid = '0;
      step();
      tests++;
      if (cdb_valid !== 1'b1 || cdb_rob_tag !== 6'd9 || cdb_data !== 32'hE9) begin
         fails++;
         $display("FAIL midreset_new: valid=%b tag=%0d data=%h want 1/9/e9", cdb_valid, cdb_rob_tag, cdb_data);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_flush();
      test_priority();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter N_PORTS, default 4, number of functional-unit requesters.
REQ-003 SHALL have parameter ROB_BUF_SIZE, default 16, ROB entries (power of two).
REQ-004 SHALL have parameter ROB_TAG_WIDTH, default $clog2(ROB_BUF_SIZE)+2, tag width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port fu_valid  input  N_PORTS  per-port result offered.
REQ-008 SHALL have port fu_ready  output  N_PORTS  per-port holding slot can accept.
REQ-009 SHALL have port fu_data  input  N_PORTS x XLEN  per-port result value.
REQ-010 SHALL have port fu_rob_tag  input  N_PORTS x ROB_TAG_WIDTH  per-port ROB tag.
REQ-011 SHALL have port fu_exception  input  N_PORTS  per-port exception flag.
REQ-012 SHALL have port fu_branch_mispredict  input  N_PORTS  per-port mispredict flag.
REQ-013 SHALL have ports flush input 1, flush_start_tag input ROB_TAG_WIDTH, rob_head input ROB_TAG_WIDTH  ROB squash request.
REQ-014 SHALL have outputs cdb_valid 1, cdb_data XLEN, cdb_rob_tag ROB_TAG_WIDTH, cdb_exception 1, branch_mispredict 1  registered CDB broadcast to ROB and reservation stations.

Function
REQ-015 SHALL hold one registered slot per port (valid, data, tag, exception, mispredict).
REQ-016 SHALL drive fu_ready[i] = !slot_valid[i] | grant[i] (combinational); transfer occurs on fu_valid[i] & fu_ready[i] at the edge.
REQ-017 SHALL grant at most one occupied slot per cycle, round-robin, search starting at last_grant+1 modulo N_PORTS.
REQ-018 SHALL load the granted slot into the CDB output registers at the edge; cdb_valid=1 exactly one cycle per grant.
REQ-019 SHALL drive cdb_valid=0 and all other CDB outputs to zero in any cycle with no grant on the previous edge.
REQ-020 SHALL give minimum latency of two edges: accept at edge N, broadcast visible after edge N+1.
REQ-021 SHALL permit accept-and-grant on the same port in one cycle: slot is refilled while old contents broadcast.
REQ-022 SHALL update last_grant only when a grant occurs.
REQ-023 SHALL compute age as (tag - rob_head) mod ROB_BUF_SIZE using the low $clog2(ROB_BUF_SIZE) bits; entry is squashed when flush=1 and age(tag) >= age(flush_start_tag).
REQ-024 SHALL, on flush, clear squashed slots at the edge, drop squashed incoming transfers, and exclude squashed slots from that cycle's grant.
REQ-025 SHALL keep non-squashed slots and the current CDB output unaffected by flush.
REQ-026 SHALL, with all slots full and no grant possible, hold fu_ready=0 until a slot drains.

Reset
REQ-027 SHALL, on reset=1 (asynchronous), clear all slot valids, set last_grant=N_PORTS-1, clear all CDB outputs to zero.
REQ-028 SHALL discard in-flight slot contents on reset mid-operation; fu_ready all ones during and after reset.

Configuration
REQ-029 SHALL support macro CDB_ARBITER_MISPREDICT_PRIORITY_EN.
REQ-030 SHALL, when defined, grant any occupied slot with branch_mispredict=1 ahead of round-robin (lowest index among such), last_grant updated normally.
REQ-031 SHALL, when undefined, use pure round-robin per REQ-017.

Verification
REQ-032 SHALL cover single port: port 0 offers data 0x7867_5645 tag 0 at edge 1 -> cdb_valid=1, cdb_data=0x7867_5645, cdb_rob_tag=0 after edge 2, 0 after edge 3.
REQ-033 SHALL cover contention: ports 0..3 offer tags 4..7 same edge -> broadcasts tags 4,5,6,7 on four consecutive cycles; second round from port 1 starts after port 0.
REQ-034 SHALL cover back-pressure: port 2 held occupied behind continuous higher-rotation traffic -> fu_ready[2]=0, no data loss, eventual broadcast within N_PORTS cycles.
REQ-035 SHALL cover flush: rob_head=4, slots hold tags 5,7,8,9, flush_start_tag=7 -> only tag 5 broadcast afterwards.
REQ-036 SHALL cover priority macro: slots tags 3 (port 0) and 6 (port 3, mispredict=1) -> defined: tag 6 first; undefined: tag 3 first.
REQ-037 SHALL cover reset mid-stream: reset asserted with three slots full -> cdb_valid=0 immediately, no broadcasts after release until new transfers.
